// File: rtl/div_sequencer.sv
// div_sequencer
// Multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting
// beside the ALU in EX. It uses radix-2 restoring division, retiring one
// quotient bit per cycle. While it works it holds the pipeline via stall,
// then presents the result together with a single-cycle done pulse.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst     in   1     synchronous active-high reset, overrides all inputs
//   valid   in   1     EX holds a div/rem instruction (held until done)
//   flush   in   1     kill the in-flight operation
//   op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a       in   XLEN  dividend (rs1)
//   b       in   XLEN  divisor (rs2)
//   stall   out  1     valid & ~done
//   busy    out  1     sequencer not idle
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  quotient or remainder of the last completed op
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  state_t          state_next;

  logic            is_rem;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] pending;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   count;
  logic            done_prev;

  logic            signed_op;
  logic            a_neg_in;
  logic            b_neg_in;
  logic            accept;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  // Accept decode and special-case detection. done_prev keeps the instruction
  // that just completed (valid still high while the pipeline advances) from
  // being accepted a second time.
  always_comb begin
    signed_op = ~op[0];
    a_neg_in  = signed_op & a[XLEN-1];
    b_neg_in  = signed_op & b[XLEN-1];
    accept    = (state == IDLE) & valid & ~flush & ~done_prev;
    div_zero  = (b == '0);
    overflow  = signed_op & (a == MIN_INT) & (b == '1);
    special   = div_zero | overflow;
    if (div_zero) begin
      special_val = op[1] ? a : '1;
    end else begin
      special_val = op[1] ? '0 : MIN_INT;
    end
  end

  // One restoring step. The partial remainder is widened by one bit before
  // the compare so divisors above 2^(XLEN-1) in unsigned ops stay exact.
  always_comb begin
    shifted = {rem, dvd[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = ~diff[XLEN];
    q_fix   = (neg_a ^ neg_b) ? -dvd : dvd;
    r_fix   = neg_a ? -rem : rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs. A flush in any non-idle state returns to
  // IDLE and suppresses the done pulse, including a flush that lands in DONE.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE) & ~flush;
    stall      = valid & ~done;
    result     = done ? pending : result_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. The dividend register doubles as the quotient: each step shifts
  // the next dividend bit out of the top and the new quotient bit into the
  // bottom. result_q only commits when a done pulse actually completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_rem    <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      pending   <= '0;
      result_q  <= '0;
      count     <= '0;
      done_prev <= 1'b0;
    end else begin
      done_prev <= done;
      if (accept) begin
        is_rem <= op[1];
        neg_a  <= a_neg_in;
        neg_b  <= b_neg_in;
        dvd    <= a_neg_in ? -a : a;
        dvs    <= b_neg_in ? -b : b;
        rem    <= '0;
        count  <= '0;
        if (special) begin
          pending <= special_val;
        end
      end else if (state == CALC && !flush) begin
        rem   <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dvd   <= {dvd[XLEN-2:0], ge};
        count <= count + CW'(1);
      end else if (state == FIX && !flush) begin
        pending <= is_rem ? r_fix : q_fix;
      end else if (done) begin
        result_q <= pending;
      end
    end
  end

  // The pipeline must keep valid high until done unless it flushes.
  assert property (@(posedge clk) disable iff (rst) busy |-> (valid | flush));

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Scoreboard bench for div_sequencer. The driver pushes the expected result
// and the cycle in which done should appear; a separate monitor pops an entry
// on every done pulse and compares result and timing.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .flush (flush),
    .op    (op),
    .a     (a),
    .b     (b),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  // Cycle index of the current clock period (changes at each rising edge).
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Golden model built on the language's signed / and %, which truncate
  // toward zero with the remainder taking the dividend's sign.
  function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (y == 32'd0) begin
      r = o[1] ? x : 32'hFFFF_FFFF;
    end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      r = o[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (o)
        DIV:     r = $signed(x) / $signed(y);
        DIVU:    r = x / y;
        REM:     r = $signed(x) % $signed(y);
        default: r = x % y;
      endcase
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_result"}, result, mon_e.res);
        checkOutput({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
      end
    end
  end

  // Issue one op in cycle 0, scramble operands after accept, wait for done,
  // then hold valid through the following cycle as the pipeline would.
  task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] expv, input int lat);
    exp_t e;
    int   st = 0;
    bit   seen = 1'b0;
    @(posedge clk);
    #1;
    valid = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.name = name;
    e.res  = expv;
    e.cyc  = cyc + lat;
    sb.push_back(e);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (stall) st++;
      if (done) begin
        seen = 1'b1;
      end else if (i > 0) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
      end
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, "_stall_cycles"}, st, lat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst   = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    applyStimulus("divu_100_7",    DIVU, 32'd100,        32'd7,          32'd14,         34);
    applyStimulus("remu_100_7",    REMU, 32'd100,        32'd7,          32'd2,          34);
    applyStimulus("div_m7_2",      DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    applyStimulus("rem_m7_2",      REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    applyStimulus("rem_7_m2",      REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34);
    applyStimulus("div_m100_m7",   DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34);
    applyStimulus("rem_m100_m7",   REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34);
    applyStimulus("div_5_0",       DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    applyStimulus("remu_5_0",      REMU, 32'd5,          32'd0,          32'd5,          1);
    applyStimulus("div_min_m1",    DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    applyStimulus("rem_min_m1",    REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
    applyStimulus("divu_min_max",  DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
    applyStimulus("remu_min_max",  REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34);
    applyStimulus("divu_bigdiv",   DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          34);
    applyStimulus("remu_bigdiv",   REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34);
    applyStimulus("divu_0_5",      DIVU, 32'd0,          32'd5,          32'd0,          34);

    $display("[TB] flush while idle");
    saved = result;
    @(posedge clk);
    #1;
    valid = 1'b1;
    flush = 1'b1;
    op    = DIVU;
    a     = 32'd50;
    b     = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("flush_idle_busy", {31'd0, busy}, 32'd0);
    valid = 1'b0;
    flush = 1'b0;

    $display("[TB] flush mid-calc");
    @(posedge clk);
    #1;
    valid = 1'b1;
    op    = DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid = 1'b0;
    checkOutput("flush_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("flush_result_kept", result, saved);
    repeat (3) begin
      @(negedge clk);
      checkOutput("flush_no_done", {31'd0, done}, 32'd0);
    end
    applyStimulus("divu_9_3_after_flush", DIVU, 32'd9, 32'd3, 32'd3, 34);

    $display("[TB] reset mid-calc");
    valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_result", result, 32'd3);
    valid = 1'b1;
    op    = DIV;
    a     = 32'hFFFF_FF9C;
    b     = 32'd7;
    repeat (6) @(posedge clk);
    #1;
    rst   = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);
    checkOutput("rst_mid_done", {31'd0, done}, 32'd0);

    $display("[TB] model-checked vectors");
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = $urandom_range(1, 20);
      if (i % 4 == 1) rb = ~rb + 32'd1 - 32'($urandom_range(0, 3));
      if (i % 7 == 6) rb = 32'd0;
      applyStimulus($sformatf("model_%0d", i), ro, ra, rb, golden(ro, ra, rb),
                    (rb == 32'd0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34);
    end

    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    checkOutput("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
